hbridge_gate_driver: RTL and testbench
======================================

Name: hbridge_gate_driver

Overview:
- Converts the wave-generation stage outputs into four full-bridge FET gate signals with dead-time insertion.
- Inputs: note sign (sign, 1 = negative half-cycle) and PWM carrier (waveOut).
- Sits between the PWM stage and the top-level pins; replaces the raw signOut/carrierOut debug outputs.
- Guarantees no shoot-through on either leg and provides a sticky fault shutdown.

Parameters:
- DEAD_CYCLES, 8, clk cycles both gates of a leg are held off between any change of that leg's conducting switch (200 ns at 40 MHz); must be ≥1, elaboration error otherwise.
- CNT_W, $clog2(DEAD_CYCLES+1), dead-time counter width (derived, not overridden).

Ports:
- clk  in  1  40 MHz system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  1 = bridge may conduct; 0 = all gates off (coast)
- sign  in  1  note sign; 0 = positive half, 1 = negative half
- carrier  in  1  PWM carrier, already in clk domain
- fault  in  1  synchronous shutdown request (overcurrent etc.)
- gateHA  out  1  leg A high-side gate
- gateLA  out  1  leg A low-side gate
- gateHB  out  1  leg B high-side gate
- gateLB  out  1  leg B low-side gate
- deadActive  out  1  1 while either leg is in DEAD
- faulted  out  1  sticky fault flag

Behaviour:
- Reset (async, immediate, no clock edge needed):
  - all gates 0, deadActive 0, faulted 0
  - both legs in OFF, input registers cleared to 0
- Input stage: enable, sign, carrier registered once per clk edge (req_q). The FSMs act only on the registered values.
- Leg requests, from registered inputs:
  - enable=0 or faulted=1: both legs OFF.
  - sign=0: legA = carrier ? HIGH : LOW; legB = LOW.
  - sign=1: legA = LOW; legB = carrier ? HIGH : LOW.
- Per-leg FSM (identical instances). States: OFF, LOW_ON, HIGH_ON, DEAD. Gates are registered from the state.
  - OFF: H=0, L=0.
    - request HIGH or LOW → DEAD, counter loaded.
    - request OFF → stay.
  - LOW_ON: L=1.
    - request ≠ LOW → DEAD, L drops on the same edge.
  - HIGH_ON: H=1.
    - request ≠ HIGH → DEAD, H drops on the same edge.
  - DEAD: H=0, L=0 for exactly DEAD_CYCLES cycles; the full dead time always completes, even if the request reverts.
    - On the final cycle, go to the current request: HIGH→HIGH_ON, LOW→LOW_ON, OFF→OFF.
- Forced OFF: a transition to OFF from any state goes directly to OFF, with gates 0 on the next edge. No dead time is required to turn off.
- Latency: carrier edge sampled at edge k.
  - Conducting gate falls after edge k+1.
  - Opposite gate rises after edge k+1+DEAD_CYCLES.
- Narrow pulses: carrier pulses shorter than DEAD_CYCLES never reach the opposite gate; they only blank the current gate for DEAD_CYCLES cycles. This is expected at low magnitude.
- Simultaneous sign and carrier changes: each leg evaluates its own request independently. Both legs may be in DEAD together.
- Fault:
  - fault=1 at edge k sets faulted=1 and forces both legs OFF at edge k.
  - faulted stays set regardless of fault and enable until reset.
- Invariants, checked by bench assertions:
  - Never H=1 and L=1 on the same leg.
  - Never a 0→1 gate transition without the prior DEAD_CYCLES cycles of that leg at H=L=0.

Test Plan:
- Reset release, enable=1, sign=0, carrier=0, DEAD_CYCLES=8 → all gates 0 for 8 cycles after req_q update (deadActive=1), then gateLA=1 and gateLB=1, gateHA=gateHB=0.
- From steady state, carrier 0→1 sampled at edge k → gateLA=0 after k+1, gateHA=1 after k+9; carrier 1→0 → gateHA=0 next cycle, gateLA=1 8 cycles later; leg B unchanged (LB=1).
- 1-cycle carrier pulse (magnitude=1) → gateHA never asserts; gateLA low for exactly 8 cycles, then returns to 1.
- sign 0→1 with carrier=1 → gateHA falls, gateLA rises 8 cycles later; gateLB falls the same edge, gateHB rises 8 cycles later; deadActive=1 throughout the gap.
- fault pulsed 1 cycle while gateHA=1 → all gates 0 next edge, faulted=1 held after fault and enable toggle, cleared only by reset.
- reset asserted asynchronously mid-DEAD and mid-HIGH_ON → all outputs 0 before the next clk edge; after release, DEAD is re-entered before any gate asserts.

Source files
------------

// File: rtl/hbridge_gate_driver_if.sv
// Gate-driver bus: bridge control inputs and FET gate / status outputs.
interface hbridge_gate_driver_if;
  logic enable;
  logic sign;
  logic carrier;
  logic fault;
  logic gateHA;
  logic gateLA;
  logic gateHB;
  logic gateLB;
  logic deadActive;
  logic faulted;

  modport master (
    output enable, sign, carrier, fault,
    input  gateHA, gateLA, gateHB, gateLB, deadActive, faulted
  );

  modport slave (
    input  enable, sign, carrier, fault,
    output gateHA, gateLA, gateHB, gateLB, deadActive, faulted
  );
endinterface

// File: rtl/hbridge_gate_driver.sv
// Full-bridge gate driver: per-leg dead-time FSMs with sticky fault shutdown.

// One half-bridge leg. reqOn=0 forces the leg off immediately; otherwise
// reqHigh selects which switch should conduct, with a full dead time
// inserted before any switch turns on.
module hbridge_gate_driver_leg #(
  parameter int DEAD_CYCLES = 8,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic reqOn,
  input  logic reqHigh,
  output logic gateH,
  output logic gateL,
  output logic dead
);
  localparam logic [1:0] OFF     = 2'd0;
  localparam logic [1:0] LOW_ON  = 2'd1;
  localparam logic [1:0] HIGH_ON = 2'd2;
  localparam logic [1:0] DEAD    = 2'd3;

  localparam logic [CNT_W-1:0] LOAD = CNT_W'(DEAD_CYCLES - 1);

  logic [1:0]       state;
  logic [1:0]       nextState;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nextCnt;

  // Next-state and dead-time countdown; turning off never waits for dead time.
  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    if (!reqOn) begin
      nextState = OFF;
      nextCnt   = '0;
    end else begin
      case (state)
        OFF: begin
          nextState = DEAD;
          nextCnt   = LOAD;
        end
        LOW_ON: begin
          if (reqHigh) begin
            nextState = DEAD;
            nextCnt   = LOAD;
          end
        end
        HIGH_ON: begin
          if (!reqHigh) begin
            nextState = DEAD;
            nextCnt   = LOAD;
          end
        end
        DEAD: begin
          if (cnt == '0) begin
            nextState = reqHigh ? HIGH_ON : LOW_ON;
          end else begin
            nextCnt = cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

  // State, counter and gates; gates are decoded from the next state so a
  // conducting gate drops on the same edge the leg leaves its ON state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= OFF;
      cnt   <= '0;
      gateH <= 1'b0;
      gateL <= 1'b0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
      gateH <= (nextState == HIGH_ON);
      gateL <= (nextState == LOW_ON);
    end
  end

  assign dead = (state == DEAD);
endmodule

module hbridge_gate_driver #(
  parameter int DEAD_CYCLES = 8
) (
  input logic                  clk,
  input logic                  reset,
  hbridge_gate_driver_if.slave bus
);
  localparam int CNT_W = $clog2(DEAD_CYCLES + 1);

  if (DEAD_CYCLES < 1) begin : gBadDeadCycles
    $error("hbridge_gate_driver: DEAD_CYCLES must be >= 1");
  end

  logic enableQ;
  logic signQ;
  logic carrierQ;
  logic faultedQ;
  logic forceOff;
  logic deadA;
  logic deadB;

  // Input register stage and sticky fault flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enableQ  <= 1'b0;
      signQ    <= 1'b0;
      carrierQ <= 1'b0;
      faultedQ <= 1'b0;
    end else begin
      enableQ  <= bus.enable;
      signQ    <= bus.sign;
      carrierQ <= bus.carrier;
      faultedQ <= faultedQ | bus.fault;
    end
  end

  // The raw fault input bypasses the input register so shutdown lands on
  // the same edge that sets the sticky flag.
  assign forceOff = !enableQ || faultedQ || bus.fault;

  hbridge_gate_driver_leg #(
    .DEAD_CYCLES (DEAD_CYCLES),
    .CNT_W       (CNT_W)
  ) legA (
    .clk     (clk),
    .reset   (reset),
    .reqOn   (!forceOff),
    .reqHigh (!signQ && carrierQ),
    .gateH   (bus.gateHA),
    .gateL   (bus.gateLA),
    .dead    (deadA)
  );

  hbridge_gate_driver_leg #(
    .DEAD_CYCLES (DEAD_CYCLES),
    .CNT_W       (CNT_W)
  ) legB (
    .clk     (clk),
    .reset   (reset),
    .reqOn   (!forceOff),
    .reqHigh (signQ && carrierQ),
    .gateH   (bus.gateHB),
    .gateL   (bus.gateLB),
    .dead    (deadB)
  );

  assign bus.deadActive = deadA | deadB;
  assign bus.faulted    = faultedQ;
endmodule

// File: tb/tb_hbridge_gate_driver.sv
// Self-checking bench for hbridge_gate_driver with a timestamp-based leg model.
module tb_hbridge_gate_driver;
  localparam int D = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hbridge_gate_driver_if bus();

  hbridge_gate_driver #(.DEAD_CYCLES(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: each leg remembers which switch conducts (0 none,
  // 1 low, 2 high) and, while blanked, the absolute cycle blanking ends.
  longint cyc = 0;
  int     cond [2];
  bit     blank [2];
  longint blankEnd [2];
  bit     mEn, mSign, mCar, mFaulted;

  always @(posedge clk or posedge reset) begin
    int want [2];
    bit off;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        cond[i] = 0;
        blank[i] = 1'b0;
        blankEnd[i] = 0;
      end
      mEn = 1'b0; mSign = 1'b0; mCar = 1'b0; mFaulted = 1'b0;
    end else begin
      cyc++;
      off = !mEn || mFaulted || (bus.fault === 1'b1);
      want[0] = off ? 0 : ((!mSign && mCar) ? 2 : 1);
      want[1] = off ? 0 : (( mSign && mCar) ? 2 : 1);
      for (int i = 0; i < 2; i++) begin
        if (want[i] == 0) begin
          cond[i] = 0;
          blank[i] = 1'b0;
        end else if (blank[i]) begin
          if (cyc == blankEnd[i]) begin
            blank[i] = 1'b0;
            cond[i] = want[i];
          end
        end else if (cond[i] != want[i]) begin
          cond[i] = 0;
          blank[i] = 1'b1;
          blankEnd[i] = cyc + D;
        end
      end
      mFaulted = mFaulted | bus.fault;
      mEn = bus.enable;
      mSign = bus.sign;
      mCar = bus.carrier;
    end
  end

  logic [5:0] dutV, expV;
  assign dutV = {bus.gateHA, bus.gateLA, bus.gateHB, bus.gateLB, bus.deadActive, bus.faulted};
  assign expV = {cond[0] == 2, cond[0] == 1, cond[1] == 2, cond[1] == 1,
                 blank[0] || blank[1], mFaulted};

  // Safety invariants: no shoot-through, and every gate turn-on is preceded
  // by at least D sampled cycles with both gates of that leg off.
  int   offRunA = 0, offRunB = 0;
  logic pHA = 1'b0, pLA = 1'b0, pHB = 1'b0, pLB = 1'b0;
  always @(negedge clk) begin
    vectors++;
    if ((bus.gateHA === 1'b1 && bus.gateLA === 1'b1) ||
        (bus.gateHB === 1'b1 && bus.gateLB === 1'b1)) begin
      miscompares++;
      $display("FAIL shoot_through at %0t: gates=%b required no H&L on a leg", $time, dutV[5:2]);
    end
    if (((bus.gateHA === 1'b1 && !pHA) || (bus.gateLA === 1'b1 && !pLA)) && offRunA < D) begin
      miscompares++;
      $display("FAIL dead_time_A at %0t: off run %0d, required >= %0d", $time, offRunA, D);
    end
    if (((bus.gateHB === 1'b1 && !pHB) || (bus.gateLB === 1'b1 && !pLB)) && offRunB < D) begin
      miscompares++;
      $display("FAIL dead_time_B at %0t: off run %0d, required >= %0d", $time, offRunB, D);
    end
    offRunA = (bus.gateHA !== 1'b1 && bus.gateLA !== 1'b1) ? offRunA + 1 : 0;
    offRunB = (bus.gateHB !== 1'b1 && bus.gateLB !== 1'b1) ? offRunB + 1 : 0;
    pHA = (bus.gateHA === 1'b1); pLA = (bus.gateLA === 1'b1);
    pHB = (bus.gateHB === 1'b1); pLB = (bus.gateLB === 1'b1);
  end

  task automatic test_reset();
    int firstLA = -1;
    int deadCnt = 0;
    bus.enable = 1'b1; bus.sign = 1'b0; bus.carrier = 1'b0; bus.fault = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (dutV !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_hold: outputs=%b required=%b", dutV, 6'b0);
    end
    reset = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      vectors++;
      if (dutV !== expV) begin
        miscompares++;
        $display("FAIL reset_release n=%0d: dut=%b model=%b", n, dutV, expV);
      end
      if (bus.deadActive === 1'b1) deadCnt++;
      if (firstLA < 0 && bus.gateLA === 1'b1) firstLA = n;
    end
    vectors++;
    if (firstLA != D + 2) begin
      miscompares++;
      $display("FAIL reset_first_LA: edge %0d required %0d", firstLA, D + 2);
    end
    vectors++;
    if (deadCnt != D) begin
      miscompares++;
      $display("FAIL reset_dead_len: %0d cycles required %0d", deadCnt, D);
    end
    vectors++;
    if (dutV[5:2] !== 4'b0101) begin
      miscompares++;
      $display("FAIL reset_steady: gates=%b required=0101", dutV[5:2]);
    end
  endtask

  task automatic test_carrier_edges();
    int firstOff, firstOn;
    for (int phase = 0; phase < 2; phase++) begin
      bus.carrier = (phase == 0);
      firstOff = -1; firstOn = -1;
      for (int n = 1; n <= 12; n++) begin
        @(negedge clk);
        vectors++;
        if (dutV !== expV) begin
          miscompares++;
          $display("FAIL carrier_edge p%0d n=%0d: dut=%b model=%b", phase, n, dutV, expV);
        end
        if (phase == 0) begin
          if (firstOff < 0 && bus.gateLA === 1'b0) firstOff = n;
          if (firstOn < 0 && bus.gateHA === 1'b1) firstOn = n;
        end else begin
          if (firstOff < 0 && bus.gateHA === 1'b0) firstOff = n;
          if (firstOn < 0 && bus.gateLA === 1'b1) firstOn = n;
        end
      end
      vectors++;
      if (firstOff != 2 || firstOn != D + 2) begin
        miscompares++;
        $display("FAIL carrier_latency p%0d: off edge %0d on edge %0d, required 2 and %0d",
                 phase, firstOff, firstOn, D + 2);
      end
    end
  endtask

  task automatic test_narrow_pulse();
    int lowLA = 0;
    bit anyHA = 1'b0;
    bus.carrier = 1'b1;
    for (int n = 1; n <= 22; n++) begin
      @(negedge clk);
      if (n == 1) bus.carrier = 1'b0;
      vectors++;
      if (dutV !== expV) begin
        miscompares++;
        $display("FAIL narrow_pulse n=%0d: dut=%b model=%b", n, dutV, expV);
      end
      if (bus.gateLA !== 1'b1) lowLA++;
      if (bus.gateHA === 1'b1) anyHA = 1'b1;
    end
    vectors++;
    if (anyHA || lowLA != D) begin
      miscompares++;
      $display("FAIL narrow_pulse_shape: HA seen=%0d LA low=%0d, required 0 and %0d", anyHA, lowLA, D);
    end
  endtask

  task automatic test_sign_change();
    int deadCnt = 0;
    int firstHAoff = -1, firstLBoff = -1;
    bus.carrier = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      vectors++;
      if (dutV !== expV) begin
        miscompares++;
        $display("FAIL sign_setup n=%0d: dut=%b model=%b", n, dutV, expV);
      end
    end
    bus.sign = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      vectors++;
      if (dutV !== expV) begin
        miscompares++;
        $display("FAIL sign_change n=%0d: dut=%b model=%b", n, dutV, expV);
      end
      if (bus.deadActive === 1'b1) deadCnt++;
      if (firstHAoff < 0 && bus.gateHA === 1'b0) firstHAoff = n;
      if (firstLBoff < 0 && bus.gateLB === 1'b0) firstLBoff = n;
    end
    vectors++;
    if (deadCnt != D || firstHAoff != 2 || firstLBoff != 2 || dutV[5:2] !== 4'b0110) begin
      miscompares++;
      $display("FAIL sign_change_shape: dead=%0d HAoff=%0d LBoff=%0d gates=%b, required %0d 2 2 0110",
               deadCnt, firstHAoff, firstLBoff, dutV[5:2], D);
    end
  endtask

  task automatic test_fault();
    bus.sign = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      vectors++;
      if (dutV !== expV) begin
        miscompares++;
        $display("FAIL fault_setup n=%0d: dut=%b model=%b", n, dutV, expV);
      end
    end
    bus.fault = 1'b1;
    @(negedge clk);
    bus.fault = 1'b0;
    vectors++;
    if (dutV[5:2] !== 4'b0000 || dutV[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL fault_shutdown: gates=%b faulted=%b, required 0000 and 1", dutV[5:2], dutV[0]);
    end
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      vectors++;
      if (dutV !== expV) begin
        miscompares++;
        $display("FAIL fault_hold n=%0d: dut=%b model=%b", n, dutV, expV);
      end
      if (n == 4) bus.enable = 1'b0;
      if (n == 8) bus.enable = 1'b1;
      bus.fault = (n == 12);
    end
    vectors++;
    if (dutV !== 6'b000001) begin
      miscompares++;
      $display("FAIL fault_sticky: outputs=%b required=000001", dutV);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (dutV !== 6'b0) begin
      miscompares++;
      $display("FAIL fault_reset_clear: outputs=%b required=%b", dutV, 6'b0);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_async_reset();
    int firstDead = -1, firstGate = -1;
    bus.carrier = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      vectors++;
      if (dutV !== expV) begin
        miscompares++;
        $display("FAIL async_setup n=%0d: dut=%b model=%b", n, dutV, expV);
      end
    end
    bus.carrier = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      vectors++;
      if (dutV !== expV) begin
        miscompares++;
        $display("FAIL async_enter_dead n=%0d: dut=%b model=%b", n, dutV, expV);
      end
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (dutV !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_mid_dead: outputs=%b required=%b", dutV, 6'b0);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.carrier = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      vectors++;
      if (dutV !== expV) begin
        miscompares++;
        $display("FAIL async_high n=%0d: dut=%b model=%b", n, dutV, expV);
      end
    end
    vectors++;
    if (bus.gateHA !== 1'b1) begin
      miscompares++;
      $display("FAIL async_high_on: gateHA=%b required=1", bus.gateHA);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (dutV !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_mid_high: outputs=%b required=%b", dutV, 6'b0);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      vectors++;
      if (dutV !== expV) begin
        miscompares++;
        $display("FAIL async_release n=%0d: dut=%b model=%b", n, dutV, expV);
      end
      if (firstDead < 0 && bus.deadActive === 1'b1) firstDead = n;
      if (firstGate < 0 && dutV[5:2] !== 4'b0000) firstGate = n;
    end
    vectors++;
    if (firstDead != 2 || firstGate != D + 2) begin
      miscompares++;
      $display("FAIL async_redead: dead edge %0d gate edge %0d, required 2 and %0d",
               firstDead, firstGate, D + 2);
    end
  endtask

  task automatic test_random();
    int toggleRange;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      vectors++;
      if (dutV !== expV) begin
        miscompares++;
        $display("FAIL random n=%0d: dut=%b model=%b", n, dutV, expV);
      end
      toggleRange = ((n / 500) % 2 == 1) ? 24 : 4;
      if (reset) reset = 1'b0;
      else if (bus.faulted === 1'b1 && $urandom_range(0, 19) == 0) reset = 1'b1;
      if ($urandom_range(0, toggleRange) == 0) bus.carrier = ~bus.carrier;
      if ($urandom_range(0, 59) == 0) bus.sign = ~bus.sign;
      if (bus.enable) begin
        if ($urandom_range(0, 99) == 0) bus.enable = 1'b0;
      end else if ($urandom_range(0, 4) == 0) begin
        bus.enable = 1'b1;
      end
      bus.fault = ($urandom_range(0, 499) == 0);
    end
    bus.fault = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.enable = 1'b0; bus.sign = 1'b0; bus.carrier = 1'b0; bus.fault = 1'b0;
    test_reset();
    test_carrier_edges();
    test_narrow_pulse();
    test_sign_change();
    test_fault();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
